// File: rtl/order_tx.sv
// order_tx: buffers 128-bit orders in a small FIFO and frames each one into an
// Avalon-ST packet on a 64-bit stream.
// Each packet is a header beat {MAGIC, LEN, seq}, then the order high half, then the order low half.
// Orders that arrive while the FIFO is full are dropped and counted.
// Optional feature macro ORDER_TX_CSUM_EN appends an XOR checksum beat to every packet.
//
// Ports
//   clk, reset_n  core clock; synchronous active-low reset
//   order_valid   order present, one cycle per order
//   order_data    order payload
//   order_ready   FIFO has room (registered)
//   tx_valid      beat valid
//   tx_ready      downstream accepts the beat
//   tx_sop        first beat of the packet
//   tx_eop        last beat of the packet
//   tx_data       beat data; first byte is in [63:56]
//   tx_empty      unused bytes in the EOP beat
//   seq_num       sequence number of the next packet to send
//   drop_cnt      saturating count of dropped orders
//   ovf           one-cycle pulse for each dropped order
module order_tx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ORDER_WIDTH = 128,
    parameter int unsigned TX_WIDTH    = 64,
    parameter logic [15:0] MAGIC       = 16'h7E01
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   order_valid,
    input  logic [ORDER_WIDTH-1:0] order_data,
    output logic                   order_ready,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_sop,
    output logic                   tx_eop,
    output logic [TX_WIDTH-1:0]    tx_data,
    output logic [2:0]             tx_empty,
    output logic [31:0]            seq_num,
    output logic [15:0]            drop_cnt,
    output logic                   ovf
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

`ifdef ORDER_TX_CSUM_EN
    localparam logic [15:0] LEN = 16'd32;
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, CSUM} state_t;
`else
    localparam logic [15:0] LEN = 16'd24;
    typedef enum logic [1:0] {IDLE, HDR, HI, LO} state_t;
`endif

    state_t state, state_next;

    logic [ORDER_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ORDER_WIDTH-1:0] head;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, count_next;
    logic                   push, pop, drop;
    logic [31:0]            seq_next;
    logic                   tx_valid_next, tx_sop_next, tx_eop_next;
    logic [2:0]             tx_empty_next;
    logic [TX_WIDTH-1:0]    tx_data_next;
`ifdef ORDER_TX_CSUM_EN
    logic [31:0]            csum;
`endif

    assign push = order_valid & order_ready;
    assign drop = order_valid & ~order_ready;
    assign head = mem[rd_ptr];

`ifdef ORDER_TX_CSUM_EN
    // XOR of the six 32-bit words of the header, HI and LO beats of the current packet.
    assign csum = {MAGIC, LEN} ^ seq_num ^ head[127:96] ^ head[95:64] ^ head[63:32] ^ head[31:0];
`endif

    // Next state, pop, and the beat to present after the next edge.
    // Because the beat is recomputed from a stable state and FIFO head,
    // it holds its value while the FSM is stalled.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        tx_sop_next   = 1'b0;
        tx_eop_next   = 1'b0;
        tx_empty_next = 3'd0;
        tx_data_next  = '0;
        case (state)
            IDLE: if (count != '0) state_next = HDR;
            HDR:  if (tx_ready) state_next = HI;
            HI:   if (tx_ready) state_next = LO;
`ifdef ORDER_TX_CSUM_EN
            LO:   if (tx_ready) state_next = CSUM;
            CSUM: if (tx_ready) begin
                pop        = 1'b1;
                state_next = (count > CW'(1)) ? HDR : IDLE;
            end
`else
            LO:   if (tx_ready) begin
                pop        = 1'b1;
                state_next = (count > CW'(1)) ? HDR : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase

        seq_next      = pop ? seq_num + 32'd1 : seq_num;
        tx_valid_next = (state_next != IDLE);

        case (state_next)
            HDR: begin
                tx_sop_next  = 1'b1;
                tx_data_next = {MAGIC, LEN, seq_next};
            end
            HI:  tx_data_next = head[TX_WIDTH +: TX_WIDTH];
            LO: begin
                tx_data_next = head[0 +: TX_WIDTH];
`ifndef ORDER_TX_CSUM_EN
                tx_eop_next  = 1'b1;
`endif
            end
`ifdef ORDER_TX_CSUM_EN
            CSUM: begin
                tx_data_next  = {csum, 32'h0};
                tx_eop_next   = 1'b1;
                tx_empty_next = 3'd4;
            end
`endif
            default: ;
        endcase
    end

    // Occupancy update.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= order_data;
    end

    // FSM state, FIFO pointers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            order_ready <= 1'b1;
            tx_valid    <= 1'b0;
            tx_sop      <= 1'b0;
            tx_eop      <= 1'b0;
            tx_data     <= '0;
            tx_empty    <= 3'd0;
            seq_num     <= 32'd0;
            drop_cnt    <= 16'd0;
            ovf         <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            order_ready <= (count_next < CW'(FIFO_DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            tx_valid    <= tx_valid_next;
            tx_sop      <= tx_sop_next;
            tx_eop      <= tx_eop_next;
            tx_data     <= tx_data_next;
            tx_empty    <= tx_empty_next;
            seq_num     <= seq_next;
            ovf         <= drop;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_order_tx.sv
// Directed self-checking bench for order_tx. Inputs change 2 time units after
// the rising edge; outputs are sampled on the falling edge.
module tb_order_tx;

`ifdef ORDER_TX_CSUM_EN
    localparam int          NB  = 4;
    localparam logic [15:0] LEN = 16'd32;
`else
    localparam int          NB  = 3;
    localparam logic [15:0] LEN = 16'd24;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          order_valid;
    logic [127:0]  order_data;
    logic          order_ready;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_sop;
    logic          tx_eop;
    logic [63:0]   tx_data;
    logic [2:0]    tx_empty;
    logic [31:0]   seq_num;
    logic [15:0]   drop_cnt;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [63:0] data;
    } beat_t;

    beat_t beats[$];
    int    beat_cyc[$];

    order_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .order_valid (order_valid),
        .order_data  (order_data),
        .order_ready (order_ready),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .tx_data     (tx_data),
        .tx_empty    (tx_empty),
        .seq_num     (seq_num),
        .drop_cnt    (drop_cnt),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Record every beat that the next rising edge will accept.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && tx_valid && tx_ready) begin
            beats.push_back({tx_sop, tx_eop, tx_empty, tx_data});
            beat_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    // Reference beat b of a packet with sequence number seq carrying order ord.
    function automatic logic [63:0] exp_beat(input int b, input logic [31:0] seq, input logic [127:0] ord);
        logic [31:0] x;
        x = {16'h7E01, LEN} ^ seq ^ ord[127:96] ^ ord[95:64] ^ ord[63:32] ^ ord[31:0];
        case (b)
            0:       return {16'h7E01, LEN, seq};
            1:       return ord[127:64];
            2:       return ord[63:0];
            default: return {x, 32'h0};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; order_valid = 1'b0; order_data = '0; tx_ready = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({order_ready, tx_valid, tx_sop, tx_eop, tx_empty, ovf} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/valid/sop/eop/empty/ovf=%b want 10000000",
                     {order_ready, tx_valid, tx_sop, tx_eop, tx_empty, ovf});
        end
        checks++;
        if ({tx_data, seq_num, drop_cnt} !== 112'h0) begin
            errors++;
            $display("FAIL reset_data: got data=%h seq=%h drop=%h want all zero", tx_data, seq_num, drop_cnt);
        end
        tick();
    endtask

    task automatic test_single();
        logic [63:0] exp_d [4];
        logic [3:0]  exp_eop;
        exp_d[1] = 64'h0000_0001_0000_0002;
        exp_d[2] = 64'h0000_0003_0000_0004;
`ifdef ORDER_TX_CSUM_EN
        exp_d[0] = 64'h7E01_0020_0000_0000;
        exp_d[3] = 64'h7E01_0024_0000_0000;
        exp_eop  = 4'b1000;
`else
        exp_d[0] = 64'h7E01_0018_0000_0000;
        exp_d[3] = 64'h0;
        exp_eop  = 4'b0100;
`endif
        beats.delete(); beat_cyc.delete();
        order_valid = 1'b1;
        order_data  = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_pre: tx_valid=%b want 0", tx_valid); end
        tick();
        order_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_e0: tx_valid=%b want 0", tx_valid); end
        tick();
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_sop, tx_data} !== {2'b11, exp_d[0]}) begin
            errors++;
            $display("FAIL single_latency: valid=%b sop=%b data=%h want 1 1 %h", tx_valid, tx_sop, tx_data, exp_d[0]);
        end
        for (int t = 0; t < 20 && beats.size() < NB; t++) tick();
        repeat (3) tick();
        checks++;
        if (beats.size() != NB) begin errors++; $display("FAIL single_count: beats=%0d want %0d", beats.size(), NB); end
        for (int i = 0; i < NB && i < beats.size(); i++) begin
            checks++;
            if (beats[i] !== {(i == 0), exp_eop[i], ((i == 3) ? 3'd4 : 3'd0), exp_d[i]}) begin
                errors++;
                $display("FAIL single_beat%0d: got sop=%b eop=%b empty=%0d data=%h want sop=%b eop=%b data=%h",
                         i, beats[i].sop, beats[i].eop, beats[i].empty, beats[i].data, (i == 0), exp_eop[i], exp_d[i]);
            end
        end
        checks++;
        if ({tx_valid, seq_num} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL single_seq: valid=%b seq=%0d want 0 1", tx_valid, seq_num);
        end
    endtask

    task automatic test_back_to_back(inout logic [31:0] exp_seq);
        logic [127:0] ord [4];
        for (int k = 0; k < 4; k++) ord[k] = {8{16'(16'hC000 + k)}} ^ {4{32'(k * 32'h0101_0000)}};
        beats.delete(); beat_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            order_valid = 1'b1; order_data = ord[k];
            tick();
        end
        order_valid = 1'b0;
        for (int t = 0; t < 60 && beats.size() < 4 * NB; t++) tick();
        repeat (3) tick();
        checks++;
        if (beats.size() != 4 * NB) begin errors++; $display("FAIL b2b_count: beats=%0d want %0d", beats.size(), 4 * NB); end
        for (int i = 0; i < 4 * NB && i < beats.size(); i++) begin
            checks++;
            if ({beats[i].sop, beats[i].eop, beats[i].data} !==
                {(i % NB == 0), (i % NB == NB - 1), exp_beat(i % NB, exp_seq + 32'(i / NB), ord[i / NB])}) begin
                errors++;
                $display("FAIL b2b_beat%0d: got sop=%b eop=%b data=%h want data=%h", i, beats[i].sop,
                         beats[i].eop, beats[i].data, exp_beat(i % NB, exp_seq + 32'(i / NB), ord[i / NB]));
            end
            checks++;
            if (beat_cyc[i] != beat_cyc[0] + i) begin
                errors++;
                $display("FAIL b2b_gap%0d: beat cycle %0d want %0d", i, beat_cyc[i], beat_cyc[0] + i);
            end
        end
        exp_seq = exp_seq + 32'd4;
        checks++;
        if (seq_num !== exp_seq) begin errors++; $display("FAIL b2b_seq: seq=%h want %h", seq_num, exp_seq); end
    endtask

    task automatic test_backpressure_drop(inout logic [31:0] exp_seq);
        logic [127:0] ord [6];
        int ovf_cnt = 0;
        int sops = 0;
        for (int k = 0; k < 6; k++) ord[k] = {4{32'(32'h5A00_0000 + k)}};
        beats.delete(); beat_cyc.delete();
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            order_valid = 1'b1; order_data = ord[k];
            @(negedge clk);
            if (ovf) ovf_cnt++;
            if (k >= 4) begin
                checks++;
                if (order_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: order_ready=%b want 0", k, order_ready); end
            end
            tick();
        end
        order_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (ovf) ovf_cnt++;
            tick();
        end
        checks++;
        if (ovf_cnt != 2) begin errors++; $display("FAIL bp_ovf: pulses=%0d want 2", ovf_cnt); end
        checks++;
        if (drop_cnt !== 16'd2) begin errors++; $display("FAIL bp_drop_cnt: drop_cnt=%0d want 2", drop_cnt); end
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_sop, tx_data} !== {2'b11, exp_beat(0, exp_seq, ord[0])}) begin
            errors++;
            $display("FAIL bp_hold: valid=%b sop=%b data=%h want 1 1 %h", tx_valid, tx_sop, tx_data, exp_beat(0, exp_seq, ord[0]));
        end
        tx_ready = 1'b1;
        for (int t = 0; t < 60 && beats.size() < 4 * NB; t++) tick();
        repeat (6) tick();
        checks++;
        if (beats.size() != 4 * NB) begin errors++; $display("FAIL bp_count: beats=%0d want %0d", beats.size(), 4 * NB); end
        for (int i = 0; i < beats.size(); i++) if (beats[i].sop) sops++;
        checks++;
        if (sops != 4) begin errors++; $display("FAIL bp_packets: packets=%0d want 4", sops); end
        for (int i = 0; i < 4 * NB && i < beats.size(); i++) begin
            checks++;
            if (beats[i].data !== exp_beat(i % NB, exp_seq + 32'(i / NB), ord[i / NB])) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h want %h", i, beats[i].data, exp_beat(i % NB, exp_seq + 32'(i / NB), ord[i / NB]));
            end
        end
        exp_seq = exp_seq + 32'd4;
    endtask

    task automatic test_seq_wrap(inout logic [31:0] exp_seq);
        logic [127:0] ord [2];
        ord[0] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        ord[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        force dut.seq_num = 32'hFFFF_FFFF;
        tick();
        release dut.seq_num;
        @(negedge clk);
        checks++;
        if (seq_num !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: seq=%h want ffffffff", seq_num); end
        tick();
        beats.delete(); beat_cyc.delete();
        for (int k = 0; k < 2; k++) begin
            order_valid = 1'b1; order_data = ord[k];
            tick();
        end
        order_valid = 1'b0;
        for (int t = 0; t < 40 && beats.size() < 2 * NB; t++) tick();
        repeat (3) tick();
        checks++;
        if (beats.size() != 2 * NB) begin errors++; $display("FAIL wrap_count: beats=%0d want %0d", beats.size(), 2 * NB); end
        for (int i = 0; i < 2 * NB && i < beats.size(); i++) begin
            checks++;
            if (beats[i].data !== exp_beat(i % NB, (i < NB) ? 32'hFFFF_FFFF : 32'h0, ord[i / NB])) begin
                errors++;
                $display("FAIL wrap_beat%0d: data=%h want %h", i, beats[i].data,
                         exp_beat(i % NB, (i < NB) ? 32'hFFFF_FFFF : 32'h0, ord[i / NB]));
            end
        end
        exp_seq = 32'd1;
        checks++;
        if (seq_num !== exp_seq) begin errors++; $display("FAIL wrap_seq: seq=%h want 1", seq_num); end
    endtask

    task automatic test_reset_mid_packet();
        logic [127:0] ord_a, ord_b, ord_c;
        bit seen = 1'b0;
        ord_a = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
        ord_b = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
        ord_c = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
        tx_ready = 1'b1;
        order_valid = 1'b1; order_data = ord_a; tick();
        order_data = ord_b; tick();
        order_valid = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (tx_valid && tx_sop) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_sop: no SOP seen, want one"); end
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_data !== ord_a[127:64]) begin errors++; $display("FAIL rst_hi: data=%h want %h", tx_data, ord_a[127:64]); end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({order_ready, tx_valid, tx_sop, tx_eop, tx_empty, ovf} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL rst_ctrl: got ready/valid/sop/eop/empty/ovf=%b want 10000000",
                     {order_ready, tx_valid, tx_sop, tx_eop, tx_empty, ovf});
        end
        checks++;
        if ({tx_data, seq_num, drop_cnt} !== 112'h0) begin
            errors++;
            $display("FAIL rst_data: got data=%h seq=%h drop=%h want all zero", tx_data, seq_num, drop_cnt);
        end
        repeat (8) tick();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: tx_valid=%b want 0 (FIFO empty)", tx_valid); end
        tick();
        beats.delete(); beat_cyc.delete();
        order_valid = 1'b1; order_data = ord_c; tick();
        order_valid = 1'b0;
        for (int t = 0; t < 20 && beats.size() < NB; t++) tick();
        repeat (5) tick();
        checks++;
        if (beats.size() != NB) begin errors++; $display("FAIL rst_after_count: beats=%0d want %0d", beats.size(), NB); end
        for (int i = 0; i < NB && i < beats.size(); i++) begin
            checks++;
            if (beats[i].data !== exp_beat(i, 32'h0, ord_c)) begin
                errors++;
                $display("FAIL rst_after_beat%0d: data=%h want %h", i, beats[i].data, exp_beat(i, 32'h0, ord_c));
            end
        end
    endtask

    initial begin
        logic [31:0] exp_seq;
        test_reset();
        test_single();
        exp_seq = 32'd1;
        test_back_to_back(exp_seq);
        test_backpressure_drop(exp_seq);
        test_seq_wrap(exp_seq);
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/order_tx.md
# order_tx

Order-side transmitter that terminates the strategy block's order interface and frames each 128-bit order into an outbound Avalon-ST packet for the MAC/network path. It buffers orders in a small FIFO, prepends a header carrying a magic, byte length and 32-bit sequence number, and serializes onto a 64-bit stream with SOP/EOP/empty and downstream backpressure. Orders that arrive while the FIFO is full are dropped and counted, never stalled.

## Interface
- FIFO_DEPTH, 4, order buffer entries (power of 2, ≥2)
- ORDER_WIDTH, 128, order payload width (fixed)
- TX_WIDTH, 64, output beat width (fixed)
- MAGIC, 16'h7E01, header magic
- clk  in  1  core clock
- reset_n  in  1  reset, synchronous, active-low
- order_valid  in  1  order present (single-cycle per order)
- order_data  in  128  order payload
- order_ready  out  1  FIFO can accept
- tx_valid  out  1  beat valid
- tx_ready  in  1  downstream accepts beat
- tx_sop  out  1  first beat of packet
- tx_eop  out  1  last beat of packet
- tx_data  out  64  beat data, first byte in [63:56]
- tx_empty  out  3  unused bytes in beat (EOP beat only)
- seq_num  out  32  sequence number of next packet to send
- drop_cnt  out  16  saturating count of dropped orders
- ovf  out  1  one-cycle pulse on each dropped order

## Operation
- Push: order_valid & order_ready writes order_data to FIFO tail.
- order_ready = (count < FIFO_DEPTH), from registered count, independent of same-cycle pop.
- Drop: order_valid & !order_ready discards order; ovf=1 next cycle; drop_cnt+1, holds at 16'hFFFF.
- FSM states: IDLE, HDR, HI, LO (plus CSUM, see Configuration).
- IDLE → HDR when count != 0.
- HDR: tx_sop=1, tx_data = {MAGIC, LEN, seq_num}; → HI on tx_ready.
- HI: tx_data = head[127:64]; → LO on tx_ready.
- LO: tx_data = head[63:0]; tx_eop=1, tx_empty=0; on tx_ready: pop head, seq_num+1, → HDR if count>1 else IDLE.
- LEN = 16'd24 (bytes including header).
- tx_valid=1 in every state except IDLE; tx_sop/tx_eop/tx_empty 0 except where stated.
- seq_num wraps 32'hFFFFFFFF → 0.
- Outputs stable while tx_valid & !tx_ready (Avalon-ST hold).
- Push into FIFO and pop from FIFO in same cycle: both occur, count unchanged.

## Timing
- Reset values: order_ready=1, tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0, tx_empty=0, seq_num=0, drop_cnt=0, ovf=0; FIFO empty, FSM IDLE.
- Latency: order accepted at edge E0; HDR beat valid after E1 (2 cycles from order_valid to tx_sop).
- Steady state with tx_ready=1: 3 cycles/packet (4 with CSUM), no idle gap between queued packets.
- Reset mid-packet: packet truncated without EOP, FIFO flushed, seq_num=0; downstream handles truncation.
- Backpressure: tx_ready=0 freezes FSM; FIFO keeps accepting until full.

## Configuration
- ORDER_TX_CSUM_EN defined: LEN = 16'd32; LO no longer has tx_eop; LO → CSUM on tx_ready (pop/seq increment move to CSUM). CSUM: tx_data = {CSUM32, 32'h0}, tx_eop=1, tx_empty=4. CSUM32 = XOR of the six 32-bit words of HDR, HI, LO. 4 cycles/packet.
- Undefined: 3-beat packets, no CSUM state, no checksum logic.

## Test plan
- Single order 128'h0000_0001_0000_0002_0000_0003_0000_0004, tx_ready=1 → beats 64'h7E01_0018_0000_0000 (sop), 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004 (eop, empty 0); seq_num 0→1.
- Same order with ORDER_TX_CSUM_EN → header 64'h7E01_0020_0000_0000; 4th beat 64'h7E01_0024_0000_0000, eop, empty=4.
- 4 back-to-back orders, tx_ready=1 → 12 contiguous beats, sop on beats 1/4/7/10, seq fields 0,1,2,3, no tx_valid gap.
- tx_ready=0, 6 orders → 4 buffered, order_ready=0 after 4th, ovf pulses twice, drop_cnt=2; release tx_ready → exactly 4 packets.
- Preload seq_num to 32'hFFFF_FFFF (via 2^32-1 packets or force) → packet carries FFFFFFFF, next carries 0.
- reset_n low during HI beat → next cycle all outputs at reset values, FIFO empty; subsequent order emits seq 0.
